uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 55 +++++
 rtl/uart_fifo.sv | 55 +++++
 rtl/uart_tx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, codes and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [2:0] BIT_COUNT_4 = 3'd0;
  localparam logic [2:0] BIT_COUNT_5 = 3'd1;
  localparam logic [2:0] BIT_COUNT_6 = 3'd2;
  localparam logic [2:0] BIT_COUNT_7 = 3'd3;
  localparam logic [2:0] BIT_COUNT_8 = 3'd4;

  // Index of the last data bit sent; out-of-range selects fall back to 8 bits.
  function automatic logic [2:0] last_bit_idx(input logic [2:0] sel);
    logic [2:0] idx;
    case (sel)
      BIT_COUNT_4: idx = 3'd3;
      BIT_COUNT_5: idx = 3'd4;
      BIT_COUNT_6: idx = 3'd5;
      BIT_COUNT_7: idx = 3'd6;
      BIT_COUNT_8: idx = 3'd7;
      default:     idx = 3'd7;
    endcase
    return idx;
  endfunction

  function automatic logic parity_en(input logic [1:0] mode);
    return !((mode == PAR_NONE) || (mode == PAR_NONE_ALT));
  endfunction

  // Parity over the selected low data bits; inverted for odd parity.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [2:0] sel,
                                       input logic [1:0] mode);
    logic       p;
    logic [2:0] last;
    p    = 1'b0;
    last = last_bit_idx(sel);
    for (int i = 0; i < 8; i++) begin
      if (3'(i) <= last) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO; head word is visible on rdata while not empty.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = level_q;

  // Pointer and occupancy tracking; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a TX FIFO and per-frame latched configuration.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | line high, waiting for enable and a queued byte
// ST_START  | start bit (line low) for one bit period
// ST_DATA   | data bits, LSB first, one per bit period
// ST_PARITY | optional parity bit
// ST_STOP   | one or two stop bits (line high)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [2:0]                    bit_count_sel,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bits_q;
  logic             stop_q;
  logic             stop2_q;
  logic [7:0]       sh_q, sh_d;
  logic             par_q;
  logic             par_en_q;
  logic             tx_q, tx_d;
  logic             done_q;
  logic             tick;
  logic             start_frame;
  logic             frame_end;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (start_frame),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready  = !fifo_full;
  assign tick      = (cnt_q == '0);
  assign frame_end = (state_q == ST_STOP) && tick && !stop_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a frame start also pops the FIFO head.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d     = ST_START;
          start_frame = 1'b1;
        end
      end
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA:   if (tick && (bits_q == 3'd0)) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP: begin
        if (frame_end) begin
          if (enable && !fifo_empty) begin
            state_d     = ST_START;
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register next value: load on frame start, shift after each data bit.
  always_comb begin
    sh_d = sh_q;
    if (start_frame)                     sh_d = fifo_head;
    else if ((state_q == ST_DATA) && tick) sh_d = sh_q >> 1;
  end

  // Outputs; tx is precomputed for the upcoming state so the flop aligns with state_q.
  always_comb begin
    busy = (state_q != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sh_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign done = done_q;

  // Baud counter, bit/stop counters, latched frame configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= '0;
      bits_q   <= '0;
      stop_q   <= 1'b0;
      stop2_q  <= 1'b0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      done_q <= frame_end;
      sh_q   <= sh_d;

      if (start_frame) begin
        div_q    <= baud_div;
        bits_q   <= last_bit_idx(bit_count_sel);
        par_q    <= calc_parity(fifo_head, bit_count_sel, parity_mode);
        par_en_q <= parity_en(parity_mode);
        stop2_q  <= stop2;
        cnt_q    <= baud_div;
      end else if (state_d == ST_IDLE) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= div_q;
      end else begin
        cnt_q <= cnt_q - DIV_W'(1);
      end

      if ((state_q == ST_DATA) && tick && (bits_q != 3'd0))
        bits_q <= bits_q - 3'd1;

      if ((state_q != ST_STOP) && (state_d == ST_STOP))
        stop_q <= stop2_q;
      else if ((state_q == ST_STOP) && tick)
        stop_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg.
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] baud_div;
  logic [2:0]  bit_count_sel;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic        done;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_cfg #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .baud_div      (baud_div),
    .bit_count_sel (bit_count_sel),
    .parity_mode   (parity_mode),
    .stop2         (stop2),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tx            (tx),
    .busy          (busy),
    .done          (done),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_busy(input int max_wait);
    int w;
    w = 0;
    while (busy !== 1'b1 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
  endtask

  // exp holds the line level per bit period in transmit order, e.g. "0101001011".
  task automatic frame_check(input string tag, input string exp, input int div, input int max_wait);
    logic ok;
    logic b;
    wait_busy(max_wait);
    chk({tag, " start"}, 32'(busy), 32'd1);
    for (int i = 0; i < exp.len(); i++) begin
      ok = 1'b1;
      b  = (exp[i] == 8'h31);
      for (int c = 0; c <= div; c++) begin
        if (tx !== b) ok = 1'b0;
        if (busy !== 1'b1) ok = 1'b0;
        if (!(i == 0 && c == 0) && done !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, i), 32'(ok), 32'd1);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic quiet;
    rst           = 1'b1;
    enable        = 1'b0;
    baud_div      = 16'd0;
    bit_count_sel = 3'd4;
    parity_mode   = 2'b00;
    stop2         = 1'b0;
    in_data       = 8'hFF;
    in_valid      = 1'b1;
    repeat (3) @(negedge clk);
    // reset state; push under reset is blocked
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    // 8N1, 4 cycles per bit, byte 0xA5
    baud_div = 16'd3;
    enable   = 1'b1;
    push(8'hA5);
    frame_check("a5_8n1", "0101001011", 3, 10);
    chk("a5 busy after", 32'(busy), 32'd0);

    // even then odd parity on 0x07
    baud_div    = 16'd1;
    parity_mode = 2'b01;
    push(8'h07);
    frame_check("par_even", "01110000011", 1, 10);
    parity_mode = 2'b10;
    push(8'h07);
    frame_check("par_odd", "01110000001", 1, 10);

    // 4 data bits, two stops, one-cycle bits
    parity_mode   = 2'b00;
    bit_count_sel = 3'd0;
    stop2         = 1'b1;
    baud_div      = 16'd0;
    push(8'h0F);
    frame_check("4n2", "0111111", 0, 10);
    chk("4n2 busy after", 32'(busy), 32'd0);

    // fill FIFO with enable low, 5th push rejected, then drain back-to-back
    bit_count_sel = 3'd4;
    stop2         = 1'b0;
    enable        = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    chk("full level", 32'(fifo_level), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    enable = 1'b1;
    frame_check("b2b_0", "0100010001", 0, 10);
    frame_check("b2b_1", "0010001001", 0, 0);
    frame_check("b2b_2", "0110011001", 0, 0);
    frame_check("b2b_3", "0001000101", 0, 0);
    chk("b2b busy after", 32'(busy), 32'd0);
    chk("b2b level after", 32'(fifo_level), 32'd0);

    // reset mid-DATA with two bytes still queued
    enable   = 1'b0;
    baud_div = 16'd1;
    push(8'h5A);
    push(8'h5A);
    push(8'h5A);
    enable = 1'b1;
    wait_busy(10);
    repeat (4) @(negedge clk);
    chk("pre-rst level", 32'(fifo_level), 32'd2);
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort level", 32'(fifo_level), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) quiet = 1'b0;
      @(negedge clk);
    end
    chk("abort quiet", 32'(quiet), 32'd1);

    // config change mid-frame only affects the next frame
    enable        = 1'b0;
    baud_div      = 16'd0;
    bit_count_sel = 3'd4;
    parity_mode   = 2'b00;
    push(8'h07);
    push(8'h07);
    enable = 1'b1;
    wait_busy(10);
    bit_count_sel = 3'd0;
    parity_mode   = 2'b01;
    frame_check("cfg_old", "0111000001", 0, 0);
    frame_check("cfg_new", "0111011", 0, 0);
    chk("cfg busy after", 32'(busy), 32'd0);

    // enable dropped mid-frame: frame completes, next one waits
    parity_mode = 2'b00;
    push(8'h03);
    push(8'h0C);
    enable = 1'b0;
    frame_check("en_off", "011001", 0, 5);
    chk("en_off level", 32'(fifo_level), 32'd1);
    repeat (10) @(negedge clk);
    chk("en_off held", 32'(busy), 32'd0);
    enable = 1'b1;
    frame_check("resume", "000111", 0, 5);
    chk("resume busy after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
